// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read-port and output-stream signal bundle for fifo_rd_ctrl.
// master = the read controller, slave = the FIFO plus downstream consumer.
interface fifo_rd_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             underflow;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    output rd_en, m_valid, m_data,
    input  rdata, empty, underflow, m_ready
  );

  modport slave (
    input  rd_en, m_valid, m_data,
    output rdata, empty, underflow, m_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Drains len words from a FIFO read port onto a valid/ready stream via a 2-entry prefetch buffer.
// Optional consecutive-empty timeout is enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_rd_ctrl #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 r_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err_underflow,
  output logic                 timeout,
  fifo_rd_ctrl_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_s;
  logic [LEN_WIDTH-1:0] remaining_r;
  logic [1:0]           occ_r;
  logic                 inflight_r;
  logic [WIDTH-1:0]     buf0_r;
  logic [WIDTH-1:0]     buf1_r;
  logic                 done_r;
  logic                 err_r;
  logic                 pop_s;
  logic                 rd_en_s;
  logic                 to_hit_s;
  logic                 accept_s;

  // Read issue: never let buffered + in-flight words exceed the two buffer slots.
  always_comb begin
    pop_s    = (occ_r != 2'd0) && bus.m_ready;
    accept_s = (state_r == IDLE) && start;
    rd_en_s  = (state_r == RUN) && !bus.empty && (remaining_r != LEN_ZERO) &&
               (({1'b0, occ_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
  end

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_r;

  // Timeout fires on the TIMEOUT-th consecutive empty cycle while reads are still owed.
  always_comb begin
    to_hit_s = (state_r == RUN) && (remaining_r != LEN_ZERO) && bus.empty &&
               (to_cnt_r == TO_LAST);
  end

  // Consecutive-empty counter and sticky timeout flag.
  always_ff @(posedge r_clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r  <= {TO_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (accept_s) begin
        timeout_r <= 1'b0;
      end else if (to_hit_s) begin
        timeout_r <= 1'b1;
      end
      if ((state_r == RUN) && (remaining_r != LEN_ZERO) && bus.empty && !to_hit_s) begin
        to_cnt_r <= to_cnt_r + TO_ONE;
      end else begin
        to_cnt_r <= {TO_W{1'b0}};
      end
    end
  end

  assign timeout = timeout_r;
`else
  // Without the timeout feature RUN simply waits on empty.
  always_comb begin
    to_hit_s = 1'b0;
  end

  assign timeout = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && (len != LEN_ZERO)) state_s = RUN;
        else                            state_s = IDLE;
      end
      RUN: begin
        if (to_hit_s || (rd_en_s && (remaining_r == LEN_ONE))) state_s = DRAIN;
        else                                                     state_s = RUN;
      end
      DRAIN: begin
        if (!inflight_r && (occ_r == 2'd0)) state_s = IDLE;
        else                                state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, remaining count, in-flight flag, done pulse and sticky underflow error.
  always_ff @(posedge r_clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      remaining_r <= LEN_ZERO;
      inflight_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= rd_en_s;
      done_r     <= (accept_s && (len == LEN_ZERO)) ||
                    ((state_r == DRAIN) && (state_s == IDLE));
      if (accept_s) begin
        remaining_r <= len;
      end else if (to_hit_s) begin
        remaining_r <= LEN_ZERO;
      end else if (rd_en_s) begin
        remaining_r <= remaining_r - LEN_ONE;
      end
      if (accept_s) begin
        err_r <= 1'b0;
      end else if ((state_r != IDLE) && bus.underflow) begin
        err_r <= 1'b1;
      end
    end
  end

  // Prefetch buffer: buf0 is always the head; a capture lands behind whatever survives the pop.
  always_ff @(posedge r_clk or negedge rst) begin
    if (!rst) begin
      occ_r  <= 2'd0;
      buf0_r <= {WIDTH{1'b0}};
      buf1_r <= {WIDTH{1'b0}};
    end else begin
      case ({inflight_r, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) buf0_r <= bus.rdata;
          else               buf1_r <= bus.rdata;
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          buf0_r <= buf1_r;
          occ_r  <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            buf0_r <= bus.rdata;
          end else begin
            buf0_r <= buf1_r;
            buf1_r <= bus.rdata;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign busy          = (state_r != IDLE);
  assign done          = done_r;
  assign err_underflow = err_r;
  assign bus.rd_en     = rd_en_s;
  assign bus.m_valid   = (occ_r != 2'd0);
  assign bus.m_data    = buf0_r;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO model with one-cycle read latency, in-order scoreboard,
// table of transfer vectors plus hand sequences for len=0, timeout and async reset.
module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len_i = 8'd0;
  logic       busy, done, err_underflow, to_flag;

  fifo_rd_ctrl_if #(.WIDTH(8)) fif ();

  fifo_rd_ctrl #(.WIDTH(8), .LEN_WIDTH(8), .TIMEOUT(8)) dut (
    .r_clk(r_clk), .rst(rst), .start(start), .len(len_i),
    .busy(busy), .done(done), .err_underflow(err_underflow), .timeout(to_flag),
    .bus(fif)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: array with read/write pointers; empty may also be forced by the bench.
  logic [7:0] fifo_mem [1024];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic       force_empty = 1'b0;
  logic [7:0] exp_q [$];

  assign fif.empty = (rd_ptr == wr_ptr) || force_empty;

  typedef struct {
    int len; int pre; int stall; int emode; int rmode; int bstart; int uf;
    int exp_words; int exp_left; int exp_fv; int exp_err;
  } vec_t;
  vec_t tbl [7];

  int n_chk = 0, n_pass = 0;
  int cnt_rd, cnt_pop, cnt_done, cnt_rd_stall, first_valid, cyc;
  bit stall_win = 1'b0, hold_prev = 1'b0;
  logic [7:0] hold_data;
  logic s_busy, s_done, s_rd, s_valid, s_err, s_to;
  logic [7:0] s_data;

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, req);
  endtask

  task automatic preload(input logic [7:0] w);
    fifo_mem[wr_ptr % 1024] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic flush();
    rd_ptr = wr_ptr;
    exp_q.delete();
  endtask

  task automatic clear_counts();
    cnt_rd = 0; cnt_pop = 0; cnt_done = 0; cnt_rd_stall = 0; first_valid = -1; cyc = -1;
  endtask

  // One clock: sample and check at negedge, let the edge happen, then update the FIFO model.
  task automatic tick();
    logic [7:0] w;
    @(negedge r_clk);
    s_busy = busy; s_done = done; s_rd = fif.rd_en; s_valid = fif.m_valid;
    s_data = fif.m_data; s_err = err_underflow; s_to = to_flag;
    cyc++;
    if (fif.empty) chk(s_rd == 1'b0, "rd_en_while_empty", s_rd, 0);
    if (hold_prev) chk(s_valid && (s_data == hold_data), "stall_hold", s_data, hold_data);
    if (s_valid && fif.m_ready) begin
      cnt_pop++;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_word", s_data, 0);
      end else begin
        w = exp_q.pop_front();
        chk(s_data == w, "m_data_order", s_data, w);
      end
    end
    if (s_valid && (first_valid < 0)) first_valid = cyc - 1;
    hold_prev = s_valid && !fif.m_ready;
    hold_data = s_data;
    if (s_rd) cnt_rd++;
    if (s_rd && stall_win) cnt_rd_stall++;
    if (s_done) begin
      cnt_done++;
      chk(s_busy == 1'b0, "busy_with_done", s_busy, 0);
    end
    @(posedge r_clk);
    #1;
    if (s_rd) begin
      fif.rdata = fifo_mem[rd_ptr % 1024];
      rd_ptr++;
    end
  endtask

  task automatic xfer(input int len_v, input int stall, input int emode, input int rmode,
                      input int bstart, input int uf,
                      output bit done_seen, output int err_at_done, output int pops_at_done);
    clear_counts();
    done_seen = 1'b0; err_at_done = 0; pops_at_done = 0;
    start = 1'b1; len_i = len_v[7:0];
    stall_win = (stall > 0);
    fif.m_ready = (stall == 0);
    tick();
    start = 1'b0;
    for (int c = 1; (c < 4000) && !done_seen; c++) begin
      stall_win = (c <= stall);
      if (stall_win)       fif.m_ready = 1'b0;
      else if (rmode != 0) fif.m_ready = ($urandom_range(0, 3) != 0);
      else                 fif.m_ready = 1'b1;
      if (emode == 1)      force_empty = (((c / 3) % 2) == 1);
      else if (emode == 2) force_empty = ($urandom_range(0, 3) == 0);
      else                 force_empty = 1'b0;
      start = (c == bstart);
      if (c == bstart) len_i = 8'd2;
      fif.underflow = (c == uf);
      tick();
      if (c == 1) begin
        chk(s_err == 1'b0, "err_cleared_by_start", s_err, 0);
        chk(s_to == 1'b0, "timeout_cleared_by_start", s_to, 0);
      end
      if (s_done) begin
        done_seen = 1'b1; err_at_done = s_err; pops_at_done = cnt_pop;
      end
    end
    start = 1'b0; fif.underflow = 1'b0; force_empty = 1'b0; fif.m_ready = 1'b1; stall_win = 1'b0;
    if (!done_seen) chk(1'b0, "done_wait_budget", 0, 1);
    repeat (3) tick();
  endtask

  initial begin
    bit ds;
    int ead, pad, to_tick;
    bit to_seen;

    tbl[0] = '{4, 4, 0, 0, 0, 0, 0, 4, 0, 2, 0};
    tbl[1] = '{4, 4, 10, 0, 0, 0, 0, 4, 0, 2, 0};
    tbl[2] = '{6, 6, 0, 1, 0, 0, 4, 6, 0, -1, 1};
    tbl[3] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 2, 0};
    tbl[4] = '{3, 5, 0, 0, 0, 2, 0, 3, 2, 2, 0};
    tbl[5] = '{8, 10, 0, 0, 1, 0, 0, 8, 2, 2, 0};
    tbl[6] = '{255, 255, 0, 2, 1, 0, 0, 255, 0, -1, 0};

    fif.rdata = 8'd0; fif.underflow = 1'b0; fif.m_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(done == 1'b0, "reset_done", done, 0);
    chk(fif.rd_en == 1'b0, "reset_rd_en", fif.rd_en, 0);
    chk(fif.m_valid == 1'b0, "reset_m_valid", fif.m_valid, 0);
    chk(fif.m_data == 8'd0, "reset_m_data", fif.m_data, 0);
    chk(err_underflow == 1'b0, "reset_err", err_underflow, 0);
    chk(to_flag == 1'b0, "reset_timeout", to_flag, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      flush();
      for (int k = 0; k < tbl[i].pre; k++)
        preload((i < 2) ? (8'h11 + k[7:0]) : 8'($urandom_range(0, 255)));
      xfer(tbl[i].len, tbl[i].stall, tbl[i].emode, tbl[i].rmode, tbl[i].bstart, tbl[i].uf,
           ds, ead, pad);
      chk(pad == tbl[i].exp_words, $sformatf("vec%0d_words_before_done", i), pad, tbl[i].exp_words);
      chk(cnt_pop == tbl[i].exp_words, $sformatf("vec%0d_word_count", i), cnt_pop, tbl[i].exp_words);
      chk(cnt_rd == tbl[i].exp_words, $sformatf("vec%0d_rd_en_count", i), cnt_rd, tbl[i].exp_words);
      chk(cnt_done == 1, $sformatf("vec%0d_done_pulses", i), cnt_done, 1);
      chk((wr_ptr - rd_ptr) == tbl[i].exp_left, $sformatf("vec%0d_fifo_left", i),
          wr_ptr - rd_ptr, tbl[i].exp_left);
      chk(ead == tbl[i].exp_err, $sformatf("vec%0d_err_at_done", i), ead, tbl[i].exp_err);
      if (tbl[i].exp_fv >= 0)
        chk(first_valid == tbl[i].exp_fv, $sformatf("vec%0d_first_valid", i), first_valid, tbl[i].exp_fv);
      if (tbl[i].stall > 0)
        chk(cnt_rd_stall <= 2, $sformatf("vec%0d_rd_during_stall", i), cnt_rd_stall, 2);
    end

    // len == 0: done on the next cycle, no reads, no data.
    flush();
    preload(8'h5A);
    clear_counts();
    start = 1'b1; len_i = 8'd0;
    tick();
    start = 1'b0;
    tick();
    chk(s_done == 1'b1, "len0_done_next_cycle", s_done, 1);
    chk(s_busy == 1'b0, "len0_not_busy", s_busy, 0);
    repeat (4) tick();
    chk(cnt_done == 1, "len0_done_pulses", cnt_done, 1);
    chk(cnt_rd == 0, "len0_rd_en_count", cnt_rd, 0);
    chk(first_valid == -1, "len0_no_m_valid", first_valid, -1);

    // Timeout: 2 of 5 words available, then the FIFO stays empty.
    flush();
    preload(8'hA1); preload(8'hA2);
    clear_counts();
    start = 1'b1; len_i = 8'd5;
    tick();
    start = 1'b0;
    ds = 1'b0; to_seen = 1'b0; to_tick = -1;
`ifdef FIFO_RD_TIMEOUT_EN
    for (int c = 1; (c < 60) && !ds; c++) begin
      tick();
      if (s_to && !to_seen) begin to_seen = 1'b1; to_tick = cyc; end
      if (s_done) begin
        ds = 1'b1;
        chk(s_to == 1'b1, "timeout_held_at_done", s_to, 1);
      end
    end
    chk(ds, "timeout_done", ds, 1);
    chk((to_tick >= 10) && (to_tick <= 12), "timeout_latency", to_tick, 11);
    chk(cnt_pop == 2, "timeout_words", cnt_pop, 2);
    repeat (3) tick();
`else
    repeat (30) begin
      tick();
      if (s_to) to_seen = 1'b1;
    end
    chk(s_busy == 1'b1, "no_timeout_still_busy", s_busy, 1);
    chk(cnt_pop == 2, "no_timeout_words_so_far", cnt_pop, 2);
    preload(8'hA3); preload(8'hA4); preload(8'hA5);
    for (int c = 1; (c < 60) && !ds; c++) begin
      tick();
      if (s_to) to_seen = 1'b1;
      if (s_done) ds = 1'b1;
    end
    chk(ds, "no_timeout_done", ds, 1);
    chk(cnt_pop == 5, "no_timeout_words", cnt_pop, 5);
    chk(to_seen == 1'b0, "timeout_stays_low", to_seen, 0);
`endif

    // Asynchronous reset mid-transfer.
    flush();
    for (int k = 0; k < 5; k++) preload(8'hC0 + k[7:0]);
    clear_counts();
    start = 1'b1; len_i = 8'd5;
    tick();
    start = 1'b0;
    for (int c = 0; (c < 50) && (cnt_pop < 2); c++) tick();
    chk(cnt_pop == 2, "rst_reached_two_words", cnt_pop, 2);
    #2 rst = 1'b0;
    #1;
    chk(busy == 1'b0, "async_rst_busy", busy, 0);
    chk(done == 1'b0, "async_rst_done", done, 0);
    chk(fif.rd_en == 1'b0, "async_rst_rd_en", fif.rd_en, 0);
    chk(fif.m_valid == 1'b0, "async_rst_m_valid", fif.m_valid, 0);
    chk(fif.m_data == 8'd0, "async_rst_m_data", fif.m_data, 0);
    chk(err_underflow == 1'b0, "async_rst_err", err_underflow, 0);
    chk(to_flag == 1'b0, "async_rst_timeout", to_flag, 0);
    hold_prev = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    flush();
    for (int k = 0; k < 3; k++) preload(8'hE0 + k[7:0]);
    xfer(3, 0, 0, 0, 0, 0, ds, ead, pad);
    chk(cnt_pop == 3, "post_rst_word_count", cnt_pop, 3);
    chk(cnt_rd == 3, "post_rst_rd_en_count", cnt_rd, 3);
    chk(cnt_done == 1, "post_rst_done_pulses", cnt_done, 1);
    chk(first_valid == 2, "post_rst_first_valid", first_valid, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side consumer for the team's FIFO read port (rd_en / rdata / empty / underflow). On a start command it drains exactly len words from the FIFO and presents them on a valid/ready output stream. It absorbs the FIFO's one-cycle read latency with a 2-entry prefetch buffer, so the stream runs at full rate and never drops data under back-pressure. It sits in the FIFO's read clock domain, between the FIFO and downstream packet or serializer logic.

Parameters:
WIDTH, 8, data word width; must equal the FIFO WIDTH.
LEN_WIDTH, 8, width of the transfer length and remaining-count.
TIMEOUT, 255, consecutive-empty cycle limit; used only with the optional feature.

Ports:
r_clk  in  1  single clock (FIFO read clock).
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle command pulse; sampled only in IDLE.
len  in  LEN_WIDTH  words to drain; sampled with start.
busy  out  1  high while state != IDLE.
done  out  1  one-cycle pulse when a transfer completes or aborts.
rd_en  out  WIDTH-independent, 1  FIFO read strobe.
rdata  in  WIDTH  FIFO read data; valid one cycle after rd_en is sampled high.
empty  in  1  FIFO empty flag.
underflow  in  1  FIFO underflow flag.
m_valid  out  1  output stream valid.
m_data  out  WIDTH  output stream data (buffer head).
m_ready  in  1  downstream ready.
err_underflow  out  1  sticky; set when underflow is seen high while busy.
timeout  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Interface: one clock (r_clk); reset is asynchronous and active-low (rst).
- Reset (rst=0, takes effect immediately):
  - State is IDLE; the remaining count, occupancy and in-flight flag are 0.
  - busy, done, rd_en, m_valid, err_underflow and timeout are 0; m_data is 0.
  - Buffer contents are cleared. A read in flight is discarded; the FIFO pointer may already have advanced, so that word is lost by design.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE with start=1 and len!=0: go to RUN, load remaining=len, clear err_underflow and timeout.
  - IDLE with start=1 and len==0: clear flags, pulse done on the next cycle, stay IDLE, issue no reads.
  - start while busy is ignored.
  - RUN to DRAIN when remaining reaches 0 (after the last rd_en).
  - DRAIN to IDLE when in-flight==0 and occupancy==0. done is high for exactly the first cycle in IDLE after this transition.
- Read issue (combinational from registered state and empty):
  - rd_en = (state==RUN) && !empty && (remaining!=0) && (occupancy + inflight - pop < 2).
  - pop = m_valid && m_ready.
  - rd_en is never high while empty=1.
  - Each rd_en decrements remaining by 1 and sets inflight for the next cycle.
- Capture: in the cycle after rd_en, rdata is written to the buffer tail at the clock edge.
  - Capture and pop in the same cycle: occupancy unchanged, order preserved.
- Stream: m_valid = (occupancy != 0); m_data = head entry.
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0.
  - Output order equals FIFO read order.
- Throughput: with empty=0 and m_ready=1, one word per cycle. First m_valid appears 2 cycles after start.
- err_underflow: set if underflow=1 in any busy cycle; held until the next accepted start or reset.
- Width: remaining is LEN_WIDTH bits, unsigned, and never decrements below 0. Occupancy is 2 bits, range 0..2.

Optional Feature:
FIFO_RD_TIMEOUT_EN.
- Defined:
  - In RUN with remaining!=0, a counter of ceil(log2(TIMEOUT+1)) bits counts consecutive cycles with empty=1. It resets to 0 on any cycle with empty=0.
  - When the count reaches TIMEOUT: set timeout (sticky until next start), force remaining=0, go to DRAIN.
  - Buffered words are still delivered, then done pulses.
- Undefined: no counter exists; RUN waits indefinitely on empty; timeout is constant 0.

Test Plan:
1. FIFO preloaded with 0x11, 0x12, 0x13, 0x14; start with len=4; m_ready=1 -> m_data 0x11..0x14 on 4 consecutive valid cycles; exactly 4 rd_en pulses; one done pulse; busy falls with done.
2. Same preload, m_ready=0 for 10 cycles, then 1 -> at most 2 rd_en pulses during the stall; m_data holds 0x11; all 4 words are then delivered in order, none lost or duplicated.
3. empty toggled 1/0 every 3 cycles during a len=6 transfer -> rd_en is never high while empty=1; 6 words delivered in order; done after the sixth word pops.
4. start with len=0 -> done pulses on the next cycle; rd_en and m_valid stay 0; start pulsed while busy in a len=3 run is ignored (still exactly 3 words).
5. underflow driven high for 1 cycle mid-transfer -> err_underflow=1 and held through done; cleared by the next start. With FIFO_RD_TIMEOUT_EN and TIMEOUT=8, empty held 1 after 2 of 5 words -> timeout=1 after 8 cycles, then done.
6. rst driven low after 2 of 5 words, mid-capture -> all outputs go to reset values without waiting for a clock edge; after release, the next start behaves normally.
